// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the I/D cache memory arbiter: state encoding,
// requester IDs, default geometry and the round-robin pick.
package riscv_mem_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // On a tie the requester that did not win last time goes next.
  function automatic logic pick_winner(input logic pend_i, input logic pend_d,
                                       input logic last);
    if (pend_i && pend_d) return ~last;
    return pend_d ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) line arbiter in front of a single memory
// port. One transaction at a time: IDLE -> BUSY -> DONE -> IDLE.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        state_q;
  logic              win_q, last_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_ready_q, d_ready_q;

  logic              pend_i, pend_d, win_d, wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [LINE_W-1:0] wdata_d;

  assign pend_i  = i_read | i_write;
  assign pend_d  = d_read | d_write;
  assign win_d   = pick_winner(pend_i, pend_d, last_q);
  // Write takes priority when a requester raises both read and write.
  assign wr_d    = (win_d == REQ_D) ? d_write : i_write;
  assign addr_d  = (win_d == REQ_D) ? d_addr  : i_addr;
  assign wdata_d = (win_d == REQ_D) ? d_wdata : i_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_q       <= REQ_I;
      last_q      <= REQ_I;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_i || pend_d) begin
            win_q       <= win_d;
            last_q      <= win_d;
            mem_read_q  <= ~wr_d;
            mem_write_q <= wr_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (mem_read_q) begin
              if (win_q == REQ_D) d_rdata_q <= mem_rdata;
              else                i_rdata_q <= mem_rdata;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_ready_q   <= (win_q == REQ_I);
            d_ready_q   <= (win_q == REQ_D);
            state_q     <= DONE;
          end
        end
        DONE: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          i_ready_q   <= 1'b0;
          d_ready_q   <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, line (128-bit) address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache-line data width.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_read  in  1  I-cache refill request, held until i_ready.
- i_write  in  1  I-cache write request (tie 0 normally), held until i_ready.
- i_addr  in  ADDR_W  I-cache line address.
- i_wdata  in  LINE_W  I-cache write line.
- i_rdata  out  LINE_W  line returned to I-cache.
- i_ready  out  1  one-cycle completion pulse to I-cache.
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready  same widths/meaning for D-cache.
- mem_read  out  1  memory read command, held until mem_ready.
- mem_write  out  1  memory write command, held until mem_ready.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  LINE_W  memory write line.
- mem_rdata  in  LINE_W  memory read line, valid with mem_ready.
- mem_ready  in  1  memory completion, one or more cycles after command.

Function
REQ-004 SHALL implement FSM IDLE, BUSY, DONE; all outputs driven from registers.
REQ-005 IDLE: a requester is pending when its read or write is high. No pending requester: stay IDLE. Otherwise latch the winner, its op, addr and wdata; go BUSY next cycle.
REQ-006 Only one requester pending: it wins.
REQ-007 Both pending: the requester not granted last wins (round-robin). The last-grant flag resets to I, so D wins the first tie.
REQ-008 Read and write both high on one requester: write SHALL be serviced; the read is not serviced in that transaction.
REQ-009 BUSY: exactly one of mem_read/mem_write high, with mem_addr/mem_wdata stable from latched values, until mem_ready is sampled high.
REQ-010 On mem_ready in BUSY:
- capture mem_rdata into the winner's rdata register (reads only; writes leave it unchanged);
- drop mem_read/mem_write;
- go DONE.
REQ-011 DONE: the winner's ready SHALL be high for exactly one cycle, the other ready low; then unconditionally go IDLE.
REQ-012 Requester inputs SHALL be ignored outside IDLE, so a requester dropping its request in the DONE cycle is never re-granted.
REQ-013 Latency with a zero-wait memory (mem_ready in first BUSY cycle):
- request seen at cycle T;
- mem command at T+1;
- ready at T+2;
- next arbitration at T+3.
REQ-014 i_rdata/d_rdata SHALL hold their last captured value until the next read completion for that requester.
REQ-015 mem_ready outside BUSY SHALL be ignored.
REQ-016 Address, data and op changes on the requester ports after the IDLE latch SHALL not affect the memory command.

Reset
REQ-017 rst_n low SHALL immediately, without a clock edge, force:
- state IDLE;
- mem_read, mem_write, i_ready, d_ready = 0;
- mem_addr, mem_wdata, i_rdata, d_rdata = 0;
- last-grant = I.
REQ-018 Reset during BUSY SHALL abandon the transaction with no ready pulse; after release, arbitration restarts from IDLE on the first clock.

Structure
REQ-019 The FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and requester IDs (REQ_I=0, REQ_D=1) SHALL live in shared package riscv_mem_pkg, alongside the default ADDR_W/LINE_W constants.
REQ-020 SHALL be a single flat module; no sub-module required.

Verification
REQ-021 I-only read at 0x0000010, mem_ready after 3 cycles with mem_rdata=0xA5..A5 -> mem_read high 3 cycles with mem_addr=0x0000010, then i_ready pulse 1 cycle with i_rdata=0xA5..A5; d_ready stays 0.
REQ-022 i_read and d_read rise together after reset -> D granted first (mem_addr=d_addr); after d_ready, I granted with no intervening D grant even if d_read reasserts.
REQ-023 D write at 0x0000020 (wdata 0x1234) then D read, zero-wait memory -> mem_write at T+1 with mem_wdata=0x1234, d_ready at T+2, mem_read for the read at T+4; d_rdata unchanged by the write.
REQ-024 d_read and d_write both high -> mem_write issued, mem_read never asserted for that transaction.
REQ-025 rst_n low mid-BUSY (asynchronously, between clock edges) -> mem_read/mem_write drop immediately, no ready pulse; after release with i_read held, a new mem_read for i_addr is issued one cycle after the first clock.
REQ-026 Spurious mem_ready in IDLE and DONE -> no state change, no rdata update.
